// File: rtl/fu_cdb_arbiter_if.sv
// rtl/fu_cdb_arbiter_if.sv - FU completion inputs and CDB broadcast outputs of fu_cdb_arbiter
interface fu_cdb_arbiter_if #(
    parameter int XLEN   = 32,
    parameter int TAG_W  = 6,
    parameter int NUM_FU = 4,
    parameter int CDB_W  = 2
);
    logic [NUM_FU-1:0]       fu_valid;
    logic [NUM_FU*TAG_W-1:0] fu_tag;
    logic [NUM_FU*XLEN-1:0]  fu_result;
    logic [NUM_FU-1:0]       fu_take_branch;
    logic [NUM_FU-1:0]       fu_ready;
    logic [CDB_W-1:0]        cdb_valid;
    logic [CDB_W*TAG_W-1:0]  cdb_tag;
    logic [CDB_W*XLEN-1:0]   cdb_value;
    logic [CDB_W-1:0]        cdb_take_branch;

    modport master (
        output fu_valid, fu_tag, fu_result, fu_take_branch,
        input  fu_ready, cdb_valid, cdb_tag, cdb_value, cdb_take_branch
    );

    modport slave (
        input  fu_valid, fu_tag, fu_result, fu_take_branch,
        output fu_ready, cdb_valid, cdb_tag, cdb_value, cdb_take_branch
    );
endinterface

// File: rtl/fu_cdb_arbiter.sv
// rtl/fu_cdb_arbiter.sv - per-FU completion FIFOs, round-robin grant onto a registered CDB; CDB_PERF_CNT_EN adds perf_conflict_cnt
module fu_cdb_arbiter #(
    parameter int XLEN   = 32,
    parameter int TAG_W  = 6,
    parameter int NUM_FU = 4,
    parameter int CDB_W  = 2,
    parameter int DEPTH  = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic squash,
    fu_cdb_arbiter_if.slave bus
`ifdef CDB_PERF_CNT_EN
    ,
    output logic [31:0] perf_conflict_cnt
`endif
);
    localparam int EW = TAG_W + XLEN + 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int RW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int SW = (CDB_W > 1) ? $clog2(CDB_W) : 1;

    // entry layout: {tag, result, take_branch}
    logic [EW-1:0] mem [NUM_FU][DEPTH];
    logic [PW-1:0] head [NUM_FU];
    logic [PW-1:0] tail [NUM_FU];
    logic [CW-1:0] count [NUM_FU];
    logic [RW-1:0] rr_ptr;

    logic [NUM_FU-1:0] push;
    logic [NUM_FU-1:0] pop;
    logic [CDB_W-1:0]  slot_valid;
    logic [EW-1:0]     slot_data [CDB_W];
    logic [RW-1:0]     rr_next;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        bus.fu_ready = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            bus.fu_ready[i] = (count[i] < CW'(DEPTH));
        end
    end

    assign push = bus.fu_valid & bus.fu_ready;

    // Grants look only at start-of-cycle counts, so a fresh push is never popped the same cycle.
    always_comb begin
        int            ngrant;
        logic [RW-1:0] idx;
        ngrant     = 0;
        idx        = '0;
        pop        = '0;
        slot_valid = '0;
        rr_next    = rr_ptr;
        for (int j = 0; j < CDB_W; j++) begin
            slot_data[j] = '0;
        end
        for (int k = 0; k < NUM_FU; k++) begin
            idx = RW'((int'(rr_ptr) + k) % NUM_FU);
            if (count[idx] != '0 && ngrant < CDB_W) begin
                pop[idx]                 = 1'b1;
                slot_valid[SW'(ngrant)]  = 1'b1;
                slot_data[SW'(ngrant)]   = mem[idx][head[idx]];
                rr_next                  = RW'((int'(idx) + 1) % NUM_FU);
                ngrant                   = ngrant + 1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || squash) begin
            for (int i = 0; i < NUM_FU; i++) begin
                head[i]  <= '0;
                tail[i]  <= '0;
                count[i] <= '0;
            end
            rr_ptr        <= '0;
            bus.cdb_valid <= '0;
            if (reset) begin
                bus.cdb_tag         <= '0;
                bus.cdb_value       <= '0;
                bus.cdb_take_branch <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (push[i]) begin
                    mem[i][tail[i]] <= {bus.fu_tag[i*TAG_W +: TAG_W],
                                        bus.fu_result[i*XLEN +: XLEN],
                                        bus.fu_take_branch[i]};
                    tail[i] <= ptr_inc(tail[i]);
                end
                if (pop[i]) begin
                    head[i] <= ptr_inc(head[i]);
                end
                count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
            end
            rr_ptr        <= rr_next;
            bus.cdb_valid <= slot_valid;
            for (int j = 0; j < CDB_W; j++) begin
                bus.cdb_tag[j*TAG_W +: TAG_W]  <= slot_data[j][EW-1 -: TAG_W];
                bus.cdb_value[j*XLEN +: XLEN]  <= slot_data[j][XLEN:1];
                bus.cdb_take_branch[j]         <= slot_data[j][0];
            end
        end
    end

`ifdef CDB_PERF_CNT_EN
    int busy;

    always_comb begin
        busy = 0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (count[i] != '0) busy = busy + 1;
        end
    end

    // Survives squash on purpose; only reset clears it.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_conflict_cnt <= '0;
        end else if (busy > CDB_W && perf_conflict_cnt != 32'hFFFF_FFFF) begin
            perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
        end
    end
`endif
endmodule
